// File: rtl/ball_pkg.sv
// Shared types and helpers for the per-ball kinematics engine.
package ball_pkg;

  typedef enum logic {
    BALL_ROLLING = 1'b0,
    BALL_STOPPED = 1'b1
  } ball_state_t;

  localparam int FRAC_BITS_DEFAULT = 6;

  // Two's-complement negate of a w-bit value; the most negative code maps to the most positive.
  function automatic logic signed [31:0] sat_neg(input logic signed [31:0] v, input int w);
    logic signed [31:0] lim;
    lim = 32'sd1 <<< (w - 1);
    if (v == -lim) return lim - 32'sd1;
    return -v;
  endfunction

endpackage

// File: rtl/ball_axis.sv
// One axis of ball motion: fixed-point position accumulator, velocity,
// friction decay toward zero and cushion bounce against [MIN_P, MAX_P].
module ball_axis
  import ball_pkg::*;
#(
  parameter int POS_W         = 11,
  parameter int VEL_W         = 11,
  parameter int FRAC_BITS     = FRAC_BITS_DEFAULT,
  parameter int INIT_POS      = 0,
  parameter int INIT_VEL      = 0,
  parameter int FRICTION_STEP = 1,
  parameter int MIN_P         = 0,
  parameter int MAX_P         = 639,
  parameter int BOUNCE_EN     = 1
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic                    i_vel_we,
  input  logic signed [VEL_W-1:0] i_vel,
  input  logic                    i_pos_we,
  input  logic        [POS_W-1:0] i_pos,
  input  logic                    i_frame,
  input  logic                    i_fric_en,
  output logic        [POS_W-1:0] o_pos,
  output logic signed [VEL_W-1:0] o_vel,
  output logic                    o_wall_hit,
  output logic                    o_next_vel_zero
);

  localparam int ACC_W = POS_W + FRAC_BITS + 1;
  localparam int PIX_W = POS_W + 1;
  localparam logic signed [ACC_W-1:0] INIT_ACC = ACC_W'(INIT_POS) << FRAC_BITS;
  localparam logic signed [VEL_W-1:0] INIT_V   = VEL_W'(INIT_VEL);
  localparam logic signed [PIX_W-1:0] MIN_PIX  = PIX_W'(MIN_P);
  localparam logic signed [PIX_W-1:0] MAX_PIX  = PIX_W'(MAX_P);
  localparam logic        [VEL_W:0]   STEP     = (VEL_W + 1)'(FRICTION_STEP);

  logic signed [ACC_W-1:0] r_acc;
  logic signed [VEL_W-1:0] r_vel;
  logic                    r_wall_hit;

  logic signed [ACC_W-1:0] w_vel_ext, w_sum, w_acc_nxt;
  logic signed [PIX_W-1:0] w_sum_pix;
  logic                    w_lo, w_hi, w_hit_nxt;
  logic signed [VEL_W-1:0] w_neg_vel, w_vel_nxt;
  logic signed [VEL_W:0]   w_vel_wide, w_fric_wide;
  logic        [VEL_W:0]   w_mag, w_mag_dec;

  assign w_vel_ext = {{(ACC_W - VEL_W){r_vel[VEL_W-1]}}, r_vel};
  assign w_sum     = r_acc + w_vel_ext;
  // Upper bits of the accumulator are the floor of the pixel position.
  assign w_sum_pix = w_sum[ACC_W-1:FRAC_BITS];
  assign w_lo      = (BOUNCE_EN != 0) && (w_sum_pix < MIN_PIX);
  assign w_hi      = (BOUNCE_EN != 0) && (w_sum_pix > MAX_PIX);
  assign w_neg_vel = VEL_W'(sat_neg(32'(r_vel), VEL_W));

  // Friction shrinks the magnitude, never crossing zero.
  assign w_vel_wide  = {r_vel[VEL_W-1], r_vel};
  assign w_mag       = r_vel[VEL_W-1] ? $unsigned(-w_vel_wide) : $unsigned(w_vel_wide);
  assign w_mag_dec   = (w_mag > STEP) ? (w_mag - STEP) : '0;
  assign w_fric_wide = r_vel[VEL_W-1] ? -$signed(w_mag_dec) : $signed(w_mag_dec);

  always_comb begin
    w_acc_nxt = r_acc;
    w_vel_nxt = r_vel;
    w_hit_nxt = 1'b0;
    if (i_vel_we || i_pos_we) begin
      if (i_vel_we) w_vel_nxt = i_vel;
      if (i_pos_we) w_acc_nxt = {1'b0, i_pos, {FRAC_BITS{1'b0}}};
    end else if (i_frame) begin
      if (w_lo) begin
        w_acc_nxt = {MIN_PIX, {FRAC_BITS{1'b0}}};
        w_vel_nxt = w_neg_vel;
        w_hit_nxt = 1'b1;
      end else if (w_hi) begin
        w_acc_nxt = {MAX_PIX, {FRAC_BITS{1'b0}}};
        w_vel_nxt = w_neg_vel;
        w_hit_nxt = 1'b1;
      end else begin
        w_acc_nxt = w_sum;
        if (i_fric_en) w_vel_nxt = VEL_W'(w_fric_wide);
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_acc      <= INIT_ACC;
      r_vel      <= INIT_V;
      r_wall_hit <= 1'b0;
    end else begin
      r_acc      <= w_acc_nxt;
      r_vel      <= w_vel_nxt;
      r_wall_hit <= w_hit_nxt;
    end
  end

  assign o_pos           = r_acc[FRAC_BITS +: POS_W];
  assign o_vel           = r_vel;
  assign o_wall_hit      = r_wall_hit;
  assign o_next_vel_zero = (w_vel_nxt == '0);

endmodule

// File: rtl/ball_motion.sv
// Per-ball kinematics engine: two axis integrators sharing a friction
// counter, write-over-frame priority and a rolling/stopped FSM.
module ball_motion
  import ball_pkg::*;
#(
  parameter int POS_W           = 11,
  parameter int VEL_W           = 11,
  parameter int FRAC_BITS       = FRAC_BITS_DEFAULT,
  parameter int INIT_X_POSITION = 0,
  parameter int INIT_Y_POSITION = 0,
  parameter int INIT_X_VELOCITY = 0,
  parameter int INIT_Y_VELOCITY = 0,
  parameter int FRICTION_PERIOD = 10,
  parameter int FRICTION_STEP   = 1,
  parameter int MIN_X           = 0,
  parameter int MAX_X           = 639,
  parameter int MIN_Y           = 0,
  parameter int MAX_Y           = 479,
  parameter int BOUNCE_EN       = 1
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic                    startOfFrame,
  input  logic                    velocityWriteEnable,
  input  logic signed [VEL_W-1:0] inVelocityX,
  input  logic signed [VEL_W-1:0] inVelocityY,
  input  logic                    positionWriteEnable,
  input  logic        [POS_W-1:0] inPosX,
  input  logic        [POS_W-1:0] inPosY,
  output logic        [POS_W-1:0] topLeftPosX,
  output logic        [POS_W-1:0] topLeftPosY,
  output logic signed [VEL_W-1:0] outVelocityX,
  output logic signed [VEL_W-1:0] outVelocityY,
  output logic                    ballStopped,
  output logic                    stopEvent,
  output logic                    wallHitX,
  output logic                    wallHitY
);

  localparam int CNT_W = (FRICTION_PERIOD > 1) ? $clog2(FRICTION_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRICTION_PERIOD - 1);
  localparam ball_state_t INIT_STATE =
    ((INIT_X_VELOCITY == 0) && (INIT_Y_VELOCITY == 0)) ? BALL_STOPPED : BALL_ROLLING;

  ball_state_t      r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_stop_evt, w_stop_nxt;

  logic w_any_we, w_frame, w_fric_en, w_zero_x, w_zero_y;

  assign w_any_we  = velocityWriteEnable || positionWriteEnable;
  assign w_frame   = startOfFrame && !w_any_we && (r_state == BALL_ROLLING);
  assign w_fric_en = (r_cnt == CNT_LAST);

  ball_axis #(
    .POS_W(POS_W), .VEL_W(VEL_W), .FRAC_BITS(FRAC_BITS),
    .INIT_POS(INIT_X_POSITION), .INIT_VEL(INIT_X_VELOCITY),
    .FRICTION_STEP(FRICTION_STEP), .MIN_P(MIN_X), .MAX_P(MAX_X), .BOUNCE_EN(BOUNCE_EN)
  ) u_axis_x (
    .clk(clk), .resetN(resetN),
    .i_vel_we(velocityWriteEnable), .i_vel(inVelocityX),
    .i_pos_we(positionWriteEnable), .i_pos(inPosX),
    .i_frame(w_frame), .i_fric_en(w_fric_en),
    .o_pos(topLeftPosX), .o_vel(outVelocityX),
    .o_wall_hit(wallHitX), .o_next_vel_zero(w_zero_x)
  );

  ball_axis #(
    .POS_W(POS_W), .VEL_W(VEL_W), .FRAC_BITS(FRAC_BITS),
    .INIT_POS(INIT_Y_POSITION), .INIT_VEL(INIT_Y_VELOCITY),
    .FRICTION_STEP(FRICTION_STEP), .MIN_P(MIN_Y), .MAX_P(MAX_Y), .BOUNCE_EN(BOUNCE_EN)
  ) u_axis_y (
    .clk(clk), .resetN(resetN),
    .i_vel_we(velocityWriteEnable), .i_vel(inVelocityY),
    .i_pos_we(positionWriteEnable), .i_pos(inPosY),
    .i_frame(w_frame), .i_fric_en(w_fric_en),
    .o_pos(topLeftPosY), .o_vel(outVelocityY),
    .o_wall_hit(wallHitY), .o_next_vel_zero(w_zero_y)
  );

  // A position-only write leaves both the state and the friction phase alone.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_stop_nxt  = 1'b0;
    if (velocityWriteEnable) begin
      w_cnt_nxt = '0;
      if (w_zero_x && w_zero_y) begin
        if (r_state == BALL_ROLLING) begin
          w_state_nxt = BALL_STOPPED;
          w_stop_nxt  = 1'b1;
        end
      end else begin
        w_state_nxt = BALL_ROLLING;
      end
    end else if (w_frame) begin
      w_cnt_nxt = w_fric_en ? '0 : r_cnt + CNT_W'(1);
      if (w_zero_x && w_zero_y) begin
        w_state_nxt = BALL_STOPPED;
        w_stop_nxt  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state    <= INIT_STATE;
      r_cnt      <= '0;
      r_stop_evt <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_stop_evt <= w_stop_nxt;
    end
  end

  assign ballStopped = (r_state == BALL_STOPPED);
  assign stopEvent   = r_stop_evt;

endmodule

// File: tb/tb_ball_motion.sv
// Self-checking bench for ball_motion: directed scenarios plus random
// traffic compared against an integer-arithmetic model of ball motion.
module tb_ball_motion;

  localparam int POS_W = 11;
  localparam int VEL_W = 11;
  localparam int IX = 100, IY = 50, IVX = 64, IVY = 0;
  localparam int MAXX = 600, MAXY = 479;

  logic                    clk = 1'b0;
  logic                    resetN = 1'b0;
  logic                    startOfFrame = 1'b0;
  logic                    velocityWriteEnable = 1'b0;
  logic signed [VEL_W-1:0] inVelocityX = '0, inVelocityY = '0;
  logic                    positionWriteEnable = 1'b0;
  logic        [POS_W-1:0] inPosX = '0, inPosY = '0;
  logic        [POS_W-1:0] topLeftPosX, topLeftPosY;
  logic signed [VEL_W-1:0] outVelocityX, outVelocityY;
  logic                    ballStopped, stopEvent, wallHitX, wallHitY;

  int n_cmp = 0;
  int n_err = 0;

  // model state: positions in 1/64 px
  int m_ax, m_ay, m_vx, m_vy, m_cnt;
  bit m_stopped, m_evt, m_hx, m_hy;

  ball_motion #(
    .INIT_X_POSITION(IX), .INIT_Y_POSITION(IY),
    .INIT_X_VELOCITY(IVX), .INIT_Y_VELOCITY(IVY), .MAX_X(MAXX)
  ) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .velocityWriteEnable(velocityWriteEnable),
    .inVelocityX(inVelocityX), .inVelocityY(inVelocityY),
    .positionWriteEnable(positionWriteEnable), .inPosX(inPosX), .inPosY(inPosY),
    .topLeftPosX(topLeftPosX), .topLeftPosY(topLeftPosY),
    .outVelocityX(outVelocityX), .outVelocityY(outVelocityY),
    .ballStopped(ballStopped), .stopEvent(stopEvent),
    .wallHitX(wallHitX), .wallHitY(wallHitY)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ax = IX * 64; m_ay = IY * 64; m_vx = IVX; m_vy = IVY; m_cnt = 0;
    m_stopped = (IVX == 0) && (IVY == 0);
    m_evt = 0; m_hx = 0; m_hy = 0;
  endtask

  function automatic int neg_sat(input int v);
    return (v == -1024) ? 1023 : -v;
  endfunction

  task automatic model_axis(inout int a, inout int v, input bit fric,
                            input int lo, input int hi, output bit hit);
    int np, pix;
    np  = a + v;
    pix = np >>> 6;
    hit = 0;
    if (pix < lo || pix > hi) begin
      a = ((pix < lo) ? lo : hi) * 64;
      v = neg_sat(v);
      hit = 1;
    end else begin
      a = np;
      if (fric) begin
        if (v > 0) v = v - 1;
        else if (v < 0) v = v + 1;
      end
    end
  endtask

  task automatic model_step(input bit sof, input bit vwe, input int vx, input int vy,
                            input bit pwe, input int px, input int py);
    bit fric;
    m_evt = 0; m_hx = 0; m_hy = 0;
    if (vwe || pwe) begin
      if (vwe) begin
        m_vx = vx; m_vy = vy; m_cnt = 0;
        if (vx == 0 && vy == 0) begin
          if (!m_stopped) m_evt = 1;
          m_stopped = 1;
        end else m_stopped = 0;
      end
      if (pwe) begin m_ax = px * 64; m_ay = py * 64; end
    end else if (sof && !m_stopped) begin
      fric  = (m_cnt == 9);
      m_cnt = fric ? 0 : m_cnt + 1;
      model_axis(m_ax, m_vx, fric, 0, MAXX, m_hx);
      model_axis(m_ay, m_vy, fric, 0, MAXY, m_hy);
      if (m_vx == 0 && m_vy == 0) begin m_stopped = 1; m_evt = 1; end
    end
  endtask

  task automatic compare_all(input string ctx);
    check_val({ctx, ".posX"}, int'(topLeftPosX), (m_ax >>> 6) & 2047);
    check_val({ctx, ".posY"}, int'(topLeftPosY), (m_ay >>> 6) & 2047);
    check_val({ctx, ".velX"}, int'(outVelocityX), m_vx);
    check_val({ctx, ".velY"}, int'(outVelocityY), m_vy);
    check_val({ctx, ".stopped"}, int'(ballStopped), int'(m_stopped));
    check_val({ctx, ".stopEvt"}, int'(stopEvent), int'(m_evt));
    check_val({ctx, ".hitX"}, int'(wallHitX), int'(m_hx));
    check_val({ctx, ".hitY"}, int'(wallHitY), int'(m_hy));
  endtask

  // Drive one cycle of inputs, advance the model at the edge, check 1 unit later.
  task automatic step(input string ctx, input bit sof, input bit vwe, input int vx, input int vy,
                      input bit pwe, input int px, input int py);
    startOfFrame        = sof;
    velocityWriteEnable = vwe;
    inVelocityX         = VEL_W'(vx);
    inVelocityY         = VEL_W'(vy);
    positionWriteEnable = pwe;
    inPosX              = POS_W'(px);
    inPosY              = POS_W'(py);
    @(posedge clk);
    model_step(sof, vwe, vx, vy, pwe, px, py);
    #1;
    compare_all(ctx);
  endtask

  task automatic frame(input string ctx);
    step(ctx, 1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic idle(input string ctx);
    step(ctx, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int vx, vy;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all("rst");
    check_val("rst.posX_const", int'(topLeftPosX), 100);
    check_val("rst.stopped_const", int'(ballStopped), 0);
    resetN = 1'b1;

    frame("f1");
    check_val("f1.posX_const", int'(topLeftPosX), 101);
    for (int i = 0; i < 9; i++) frame("f10");
    check_val("f10.velX_const", int'(outVelocityX), 63);

    step("wr_sof", 1, 1, -3, 2, 0, 0, 0);
    check_val("wr_sof.velX_const", int'(outVelocityX), -3);
    check_val("wr_sof.velY_const", int'(outVelocityY), 2);
    check_val("wr_sof.posX_const", int'(topLeftPosX), 110);
    idle("idle");

    step("wr_v1", 0, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) frame("decay");
    check_val("decay.velX_const", int'(outVelocityX), 0);
    check_val("decay.stopEvt_const", int'(stopEvent), 1);
    idle("decay_after");
    check_val("decay.stopEvt_drop", int'(stopEvent), 0);
    check_val("decay.stopped_const", int'(ballStopped), 1);
    for (int i = 0; i < 5; i++) frame("stopped");

    step("bounce_set", 0, 1, 128, 0, 1, 599, 240);
    frame("bounce");
    check_val("bounce.posX_const", int'(topLeftPosX), 600);
    check_val("bounce.velX_const", int'(outVelocityX), -128);
    check_val("bounce.hitX_const", int'(wallHitX), 1);
    idle("bounce_after");
    check_val("bounce.hitX_drop", int'(wallHitX), 0);

    step("minb_set", 0, 1, -1024, 0, 1, 5, 100);
    frame("minb");
    check_val("minb.posX_const", int'(topLeftPosX), 0);
    check_val("minb.velX_const", int'(outVelocityX), 1023);

    step("wr_zero", 0, 1, 0, 0, 0, 0, 0);
    check_val("wr_zero.stopEvt_const", int'(stopEvent), 1);
    step("wr_roll", 0, 1, 64, -64, 0, 0, 0);
    step("pos_wr", 0, 0, 0, 0, 1, 320, 240);
    step("pre_rst", 1, 1, 200, 0, 1, 599, 240);
    frame("pre_rst_hit");
    #3 resetN = 1'b0;
    model_reset();
    #1 compare_all("rst_mid");
    @(posedge clk);
    #1 compare_all("rst_hold");
    resetN = 1'b1;
    idle("rst_rel");

    for (int i = 0; i < 600; i++) begin
      if (i == 300) begin
        #2 resetN = 1'b0;
        model_reset();
        #1 compare_all("rnd_rst");
        resetN = 1'b1;
      end
      if ($urandom_range(0, 3) == 0) begin
        vx = int'($urandom_range(0, 2047)) - 1024;
        vy = int'($urandom_range(0, 2047)) - 1024;
      end else begin
        vx = int'($urandom_range(0, 6)) - 3;
        vy = int'($urandom_range(0, 6)) - 3;
      end
      step("rnd", $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0, vx, vy,
           $urandom_range(0, 31) == 0, int'($urandom_range(0, 700)),
           int'($urandom_range(0, 600)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ball_motion.md
# ball_motion

Per-ball kinematics engine for the billiard table. It is a parametrised successor to the single-ball position/velocity integrator. It keeps fixed-point position and velocity per axis, integrates once per video frame, and applies periodic friction that saturates at zero. It also handles cushion bounces against programmable table bounds, accepts velocity and position overrides from the collision controller, and tracks a rolling/stopped state with event pulses. One instance per ball sits between the collision controller and the ball drawer.

## Interface
Parameters:
- POS_W, 11, pixel width of position outputs (unsigned)
- VEL_W, 11, velocity width (signed), units of 1/2^FRAC_BITS px/frame
- FRAC_BITS, 6, fractional bits of the position accumulator
- INIT_X_POSITION / INIT_Y_POSITION, 0, reset top-left position in pixels
- INIT_X_VELOCITY / INIT_Y_VELOCITY, 0, reset velocity
- FRICTION_PERIOD, 10, frames between friction steps (>=1)
- FRICTION_STEP, 1, velocity magnitude removed per friction step
- MIN_X, MAX_X, MIN_Y, MAX_Y, 0/639/0/479, legal top-left range in pixels
- BOUNCE_EN, 1, 1 = clamp and reflect at bounds; 0 = no bound check

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- startOfFrame  in  1  one-cycle frame strobe
- velocityWriteEnable  in  1  load inVelocityX/Y
- inVelocityX, inVelocityY  in  VEL_W signed  velocity to load
- positionWriteEnable  in  1  load inPosX/Y (ball placement)
- inPosX, inPosY  in  POS_W  pixel position to load, fraction cleared
- topLeftPosX, topLeftPosY  out  POS_W  integer pixel position
- outVelocityX, outVelocityY  out  VEL_W signed  current velocity
- ballStopped  out  1  high while both velocities are zero
- stopEvent  out  1  one-cycle pulse on ROLLING->STOPPED
- wallHitX, wallHitY  out  1  one-cycle pulse on bounce in that axis

## Operation
- Accumulator per axis: signed, POS_W+FRAC_BITS+1 bits. Position output = accumulator >> FRAC_BITS (floor).
- Priority per cycle: any write (velocity and/or position, both may apply together) > frame update > hold.
- A write cycle suppresses integration, even if startOfFrame is also high. A velocity write resets the friction counter to 0.
- Frame update (startOfFrame, no write, state ROLLING):
  - newPos = pos + v, using the old v.
  - Friction counter increments. When it reaches FRICTION_PERIOD-1, it wraps to 0 and |v| is reduced by min(|v|, FRICTION_STEP). No sign flip.
  - Bounce (BOUNCE_EN=1): if newPos < MIN, or newPos > MAX (compared in pixel units), position = bound with fraction 0. Velocity = -(old v); friction is skipped for that axis on that frame. wallHit pulses.
  - Negation saturates: -2^(VEL_W-1) becomes 2^(VEL_W-1)-1.
- FSM states:
  - ROLLING -> STOPPED when both post-update velocities are 0; stopEvent pulses.
  - STOPPED -> ROLLING on a velocity write with any nonzero component.
  - In STOPPED, frames change nothing; the counter holds.
  - Writing zero velocity while ROLLING goes to STOPPED with stopEvent.
- Position write in STOPPED does not change state.

## Timing
- All outputs registered. Updates are visible the cycle after the strobe/write cycle. Pulses last exactly one cycle.
- Reset values:
  - Position = INIT_*_POSITION, fraction 0.
  - Velocity = INIT_*_VELOCITY.
  - Friction counter 0.
  - wallHit/stopEvent 0.
  - State and ballStopped = STOPPED/1 if both init velocities are 0, else ROLLING/0.
- Reset mid-motion returns immediately to the reset values; no pending pulse survives.
- Back-to-back frame strobes on consecutive cycles are each processed fully.

## Structure
- Package ball_pkg: state enum (BALL_ROLLING, BALL_STOPPED), a FRAC_BITS default constant, and a saturating-negate function.
- Sub-module ball_axis, instantiated twice (X, Y), containing:
  - accumulator, velocity, friction subtraction and bound check
  - friction-step enable from the top
  - wallHit and zero-velocity flag back to the top
- Top-level responsibilities: shared friction counter, FSM, write priority.

## Test plan
- Reset with INIT_X_POSITION=100, INIT_X_VELOCITY=64 -> topLeftPosX=100 and ballStopped=0; after 1 frame topLeftPosX=101; after 10 frames outVelocityX=63.
- velocityWriteEnable with (-3, 2) in the same cycle as startOfFrame -> next cycle outVelocity=(-3, 2), position unchanged, friction counter 0.
- vx=1, vy=0, ROLLING -> after 10 frames vx=0, stopEvent high for one cycle, ballStopped=1; 5 further frames leave the position unchanged.
- MAX_X=600, pos=599, vx=128 -> after one frame topLeftPosX=600, vx=-128, wallHitX pulses once.
- MIN_X=0, vx=-1024 (VEL_W=11), pos=5 -> after one frame topLeftPosX=0, vx=+1023.
- positionWriteEnable (320, 240) while ROLLING, then reset asserted mid-frame -> outputs return to INIT values, no pulses.
